// File: rtl/operand_scoreboard_ctrl.sv
// Operand scoreboard and hazard control for the decode/fetch-operand stage.
// Tracks busy registers, gates issue on RAW/WAW, and sequences halt/drain.
module operand_scoreboard_ctrl #(
    parameter int NREGS       = 16,
    parameter int STALL_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [3:0]       srcReg1,
    input  logic [3:0]       srcReg2,
    input  logic [3:0]       nextDestReg,
    input  logic             dec_rd1,
    input  logic             dec_rd2,
    input  logic             dec_wr,
    input  logic             halt_req,
    input  logic             wb_valid,
    input  logic [3:0]       wb_reg,
    output logic             inuse1,
    output logic             inuse2,
    output logic             issue,
    output logic             stall,
    output logic             halted,
    output logic [NREGS-1:0] busy_vec,
    output logic [7:0]       stall_cycles,
    output logic             stall_timeout
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    state_t           state_q, state_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             halted_q, halted_d;

    logic [NREGS-1:0] clr;
    logic [NREGS-1:0] set;
    logic [NREGS-1:0] eff_busy;
    logic             raw;
    logic             waw;
    logic             hazard;
    logic             run;

    // Writeback bypass: a register written this cycle reads as free.
    always_comb begin
        clr = '0;
        if (wb_valid) begin
            clr[wb_reg] = 1'b1;
        end
        eff_busy = busy_q & ~clr;
        inuse1   = eff_busy[srcReg1];
        inuse2   = eff_busy[srcReg2];
        raw      = (dec_rd1 & inuse1) | (dec_rd2 & inuse2);
        waw      = dec_wr & eff_busy[nextDestReg];
        hazard   = raw | waw;
        run      = (state_q == RUN);
        issue    = run & dec_valid & ~hazard;
        stall    = (run & dec_valid & hazard) | ~run;
    end

    // New writer owns the register even when it is retired this cycle.
    always_comb begin
        set = '0;
        if (issue && dec_wr) begin
            set[nextDestReg] = 1'b1;
        end
        busy_d = eff_busy | set;
    end

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (run) begin
            if (issue) begin
                cnt_d = 8'd0;
            end else if (stall) begin
                if (cnt_q != 8'hff) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (cnt_d == LIMIT) begin
                    timeout_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (busy_d == '0) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            busy_q    <= '0;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            halted_q  <= halted_d;
        end
    end

    assign busy_vec      = busy_q;
    assign stall_cycles  = cnt_q;
    assign stall_timeout = timeout_q;
    assign halted        = halted_q;

endmodule
